// File: rtl/calc_uart_pkg.sv
// Shared definitions for the calculator UART transmit path: operation codes,
// FSM state encodings and the result byte-count helper.
// Optional feature macro: CALC_UART_PARITY_EN (adds an even parity bit, 8E1).
package calc_uart_pkg;

   // Operation select encodings
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_PASS = 3'b110;
   localparam logic [2:0] OP_CMP  = 3'b111;

   // Transaction FSM states; the frame serialiser walks START..STOP for each byte
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_DATA,
`ifdef CALC_UART_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } uart_state_e;

   // Byte sequencer states in the top level
   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_LOAD,
      SEQ_SEND
   } seq_state_e;

   // Number of bytes needed to carry a 2*data_w-bit result
   function automatic int num_bytes(input int data_w);
      return (2 * data_w + 7) / 8;
   endfunction

endpackage

// File: rtl/uart_frame_ser.sv
// One-byte UART frame serialiser: start bit, 8 data bits LSB first,
// optional even parity bit, stop bit. A new byte may be loaded in the last
// cycle of the stop bit so consecutive frames run with no idle gap.
// Optional feature macro: CALC_UART_PARITY_EN.
module uart_frame_ser
   import calc_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [7:0] byte_in,
   output logic       ready,
   output logic       txd
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   uart_state_e       state_q;
   logic [BAUD_W-1:0] baud_q;
   logic [BAUD_W-1:0] baud_inc;
   logic [2:0]        bit_q;
   logic [7:0]        shift_q;
   logic              txd_q;
   logic              bit_end;
`ifdef CALC_UART_PARITY_EN
   logic              parity_q;
`endif

   assign baud_inc = baud_q + BAUD_W'(1);
   assign bit_end  = (baud_q == BAUD_LAST);
   // Accept a byte while idle or in the final cycle of the stop bit
   assign ready    = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end);
   assign txd      = txd_q;

   // Frame sequencing with registered line output; counters clear on every state entry
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values, independent of statement order.
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         txd_q    <= 1'b1;
`ifdef CALC_UART_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else if (load && ready) begin
         state_q  <= ST_START;
         shift_q  <= byte_in;
         baud_q   <= '0;
         txd_q    <= 1'b0;
`ifdef CALC_UART_PARITY_EN
         parity_q <= ^byte_in;
`endif
      end else begin
         case (state_q)
            ST_START: begin
               if (bit_end) begin
                  state_q <= ST_DATA;
                  baud_q  <= '0;
                  bit_q   <= '0;
                  txd_q   <= shift_q[0];
               end else begin
                  baud_q  <= baud_inc;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
`ifdef CALC_UART_PARITY_EN
                     state_q <= ST_PARITY;
                     txd_q   <= parity_q;
`else
                     state_q <= ST_STOP;
                     txd_q   <= 1'b1;
`endif
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     shift_q <= {1'b0, shift_q[7:1]};
                     txd_q   <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_inc;
               end
            end
`ifdef CALC_UART_PARITY_EN
            ST_PARITY: begin
               if (bit_end) begin
                  state_q <= ST_STOP;
                  baud_q  <= '0;
                  txd_q   <= 1'b1;
               end else begin
                  baud_q  <= baud_inc;
               end
            end
`endif
            ST_STOP: begin
               if (bit_end) begin
                  state_q <= ST_IDLE;
                  baud_q  <= '0;
                  txd_q   <= 1'b1;
               end else begin
                  baud_q  <= baud_inc;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               baud_q  <= '0;
               txd_q   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/calc_uart_frame_tx.sv
// Calculator transmit path: two operand registers, an eight-operation ALU and
// a byte sequencer that sends the 2*DATA_W-bit result LSB byte first as
// back-to-back UART frames. DATA_W legal range is 4..16.
// Optional feature macro: CALC_UART_PARITY_EN (8E1 framing instead of 8N1).
module calc_uart_frame_tx
   import calc_uart_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 434
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              save_a_n,
   input  logic              save_b_n,
   input  logic [DATA_W-1:0] data_input,
   input  logic [2:0]        op,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              uart_txd
);

   localparam int RES_W     = 2 * DATA_W;
   localparam int NUM_BYTES = num_bytes(DATA_W);
   localparam int PAD_W     = 8 * NUM_BYTES;
   localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   logic [DATA_W-1:0] a_q, b_q;
   logic [RES_W-1:0]  result_q;
   logic [RES_W-1:0]  alu_res;
   logic [PAD_W-1:0]  res_pad;
   seq_state_e        seq_q;
   logic [IDX_W-1:0]  byte_idx_q;
   logic [IDX_W:0]    nxt_idx;
   logic              last_byte;
   logic              busy_q, done_q;
   logic              ser_load, ser_ready;
   logic [7:0]        ser_byte;

   assign busy = busy_q;
   assign done = done_q;

   // ALU on the held operands; narrow results are zero-extended
   always_comb begin
      // NOTE: default assignment first so no path through the case leaves alu_res unassigned and infers a latch.
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = RES_W'(a_q) + RES_W'(b_q);
         OP_SUB:  alu_res = RES_W'(a_q) - RES_W'(b_q);
         OP_MUL:  alu_res = RES_W'(a_q) * RES_W'(b_q);
         OP_AND:  alu_res = RES_W'(a_q & b_q);
         OP_OR:   alu_res = RES_W'(a_q | b_q);
         OP_XOR:  alu_res = RES_W'(a_q ^ b_q);
         OP_PASS: alu_res = RES_W'(a_q);
         OP_CMP:  alu_res = RES_W'({a_q > b_q, a_q == b_q, a_q < b_q});
         default: alu_res = '0;
      endcase
   end

   // Operand registers, frozen while a transaction is in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q <= '0;
         b_q <= '0;
      end else if (!busy_q) begin
         if (!save_a_n) a_q <= data_input;
         if (!save_b_n) b_q <= data_input;
      end
   end

   // Byte to hand the serialiser: byte 0 from LOAD, otherwise the one after the current
   assign res_pad   = PAD_W'(result_q);
   assign last_byte = (byte_idx_q == IDX_W'(NUM_BYTES - 1));
   assign nxt_idx   = (seq_q == SEQ_LOAD) ? '0 : ({1'b0, byte_idx_q} + (IDX_W + 1)'(1));

   // Byte multiplexer over the padded result
   always_comb begin
      ser_byte = '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (nxt_idx == (IDX_W + 1)'(i)) ser_byte = res_pad[8*i +: 8];
      end
   end

   assign ser_load = (seq_q == SEQ_LOAD) ||
                     ((seq_q == SEQ_SEND) && ser_ready && !last_byte);

   // Transaction sequencer with registered busy/done
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seq_q      <= SEQ_IDLE;
         result_q   <= '0;
         byte_idx_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (seq_q)
            SEQ_IDLE: begin
               if (start) begin
                  seq_q      <= SEQ_LOAD;
                  result_q   <= alu_res;
                  byte_idx_q <= '0;
                  busy_q     <= 1'b1;
               end
            end
            SEQ_LOAD: begin
               seq_q <= SEQ_SEND;
            end
            SEQ_SEND: begin
               if (ser_ready) begin
                  if (last_byte) begin
                     seq_q  <= SEQ_IDLE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     byte_idx_q <= byte_idx_q + IDX_W'(1);
                  end
               end
            end
            default: begin
               seq_q  <= SEQ_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   uart_frame_ser #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (ser_load),
      .byte_in(ser_byte),
      .ready  (ser_ready),
      .txd    (uart_txd)
   );

endmodule

// File: tb/tb_calc_uart_frame_tx.sv
// Self-checking bench for calc_uart_frame_tx (DATA_W=8, CLKS_PER_BIT=4).
// Stimulus pushes expected bytes into a scoreboard queue; a UART receiver
// process decodes the line and compares each frame as it completes.
// Honours CALC_UART_PARITY_EN when the design is built with it.
module tb_calc_uart_frame_tx;
   import calc_uart_pkg::*;

   localparam int DATA_W = 8;
   localparam int CPB    = 4;
`ifdef CALC_UART_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int DONE_CYC = 2 + 2 * FRAME_BITS * CPB;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              save_a_n;
   logic              save_b_n;
   logic [DATA_W-1:0] data_input;
   logic [2:0]        op;
   logic              start;
   logic              busy;
   logic              done;
   logic              uart_txd;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];

   calc_uart_frame_tx #(
      .DATA_W      (DATA_W),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .save_a_n  (save_a_n),
      .save_b_n  (save_b_n),
      .data_input(data_input),
      .op        (op),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .uart_txd  (uart_txd)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic load_a(input logic [7:0] v);
      data_input = v; save_a_n = 1'b0;
      @(negedge clk);
      save_a_n = 1'b1;
   endtask

   task automatic load_b(input logic [7:0] v);
      data_input = v; save_b_n = 1'b0;
      @(negedge clk);
      save_b_n = 1'b1;
   endtask

   task automatic load_both(input logic [7:0] v);
      data_input = v; save_a_n = 1'b0; save_b_n = 1'b0;
      @(negedge clk);
      save_a_n = 1'b1; save_b_n = 1'b1;
   endtask

   // Called at a negedge: start is high during cycle 0, checks cycles 1 and 2
   task automatic issue_start(input string name, input logic [2:0] o,
                              input logic [7:0] e0, input logic [7:0] e1);
      exp_q.push_back(e0);
      exp_q.push_back(e1);
      op    = o;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, "_busy_c1"}, busy, 1);
      check({name, "_done_c1"}, done, 0);
      @(negedge clk);
      check({name, "_startbit_c2"}, uart_txd, 0);
   endtask

   // Bounded wait for done; optionally pokes start/save_a_n mid-transmission
   task automatic wait_done(input string name, input bit inject);
      int cyc;
      cyc = 2;
      while (done !== 1'b1 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (inject && cyc == 20) begin
            start = 1'b1; save_a_n = 1'b0; data_input = 8'h55;
         end
         if (inject && cyc == 21) begin
            start = 1'b0; save_a_n = 1'b1;
         end
      end
      check({name, "_done_cycle"}, cyc, DONE_CYC);
      check({name, "_busy_at_done"}, busy, 0);
   endtask

   // UART receiver and scoreboard comparison
   initial begin
      logic [7:0] rx_byte;
      logic       rx_ok;
      logic       rx_stop;
      logic       rx_par;
      logic [7:0] exp_b;
      rx_byte = '0; rx_stop = 1'b0; rx_par = 1'b0;
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1 && uart_txd === 1'b0) begin
            rx_ok = 1'b1;
            for (int b = 0; b < FRAME_BITS - 1 && rx_ok; b++) begin
               for (int k = 0; k < ((b == 0) ? 5 : 4) && rx_ok; k++) begin
                  @(negedge clk);
                  if (reset_n !== 1'b1) rx_ok = 1'b0;
               end
               if (rx_ok) begin
                  if (b < 8) rx_byte[b] = uart_txd;
                  else if (b == FRAME_BITS - 2) rx_stop = uart_txd;
                  else rx_par = uart_txd;
               end
            end
            if (rx_ok) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL frame_unexpected: actual=0x%0h required=no frame", rx_byte);
               end else begin
                  exp_b = exp_q.pop_front();
                  check("frame_byte", rx_byte, exp_b);
                  check("frame_stop", rx_stop, 1);
`ifdef CALC_UART_PARITY_EN
                  check("frame_parity", rx_par, ^exp_b);
`endif
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0; save_a_n = 1'b1; save_b_n = 1'b1;
      data_input = '0; op = '0; start = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("reset_txd", uart_txd, 1);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);

      // Operand loads cause no line activity
      load_a(8'h0F);
      load_b(8'h01);
      repeat (4) @(negedge clk);
      check("idle_txd", uart_txd, 1);
      check("idle_busy", busy, 0);

      // Add: 0x0F + 0x01 = 0x0010
      issue_start("add", OP_ADD, 8'h10, 8'h00);
      wait_done("add", 1'b0);
      @(negedge clk);
      check("add_done_one_cycle", done, 0);

      // Subtract: 0x03 - 0x05 = 0xFFFE
      load_a(8'h03);
      load_b(8'h05);
      issue_start("sub", OP_SUB, 8'hFE, 8'hFF);
      wait_done("sub", 1'b0);
      @(negedge clk);

      // Multiply: 0xFF * 0xFF = 0xFE01
      load_a(8'hFF);
      load_b(8'hFF);
      issue_start("mul", OP_MUL, 8'h01, 8'hFE);
      wait_done("mul", 1'b0);
      @(negedge clk);

      // Compare with both strobes in one cycle: A==B -> 0x0002
      load_both(8'h07);
      issue_start("cmp", OP_CMP, 8'h02, 8'h00);
      wait_done("cmp", 1'b0);
      @(negedge clk);

      // Start and save_a_n while busy are ignored; restart on the done cycle
      load_a(8'h0F);
      load_b(8'h01);
      issue_start("busy_ign", OP_ADD, 8'h10, 8'h00);
      wait_done("busy_ign", 1'b1);
      issue_start("pass_on_done", OP_PASS, 8'h0F, 8'h00);
      wait_done("pass_on_done", 1'b0);
      @(negedge clk);

      // Reset in the DATA state returns the line high immediately
      issue_start("rst_mid", OP_ADD, 8'h10, 8'h00);
      repeat (10) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("rst_mid_txd", uart_txd, 1);
      check("rst_mid_busy", busy, 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("post_rst_txd", uart_txd, 1);
      load_a(8'h0F);
      load_b(8'h01);
      issue_start("post_rst_add", OP_ADD, 8'h10, 8'h00);
      wait_done("post_rst_add", 1'b0);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/calc_uart_frame_tx.md
Name: calc_uart_frame_tx

Overview:
- Parametrised successor of the latch/ALU/UART calculator path.
- Holds two DATA_W-bit operands and computes one of eight selectable operations into a 2*DATA_W-bit result.
- Serialises that result as NUM_BYTES back-to-back 8N1 UART frames, LSB byte first, with a built-in baud divider.
- Sits between board switches/buttons and the TX pin, with a start/busy/done handshake for a controlling FSM.

Parameters:
- DATA_W, 8, operand width in bits (legal range 4..16).
- CLKS_PER_BIT, 434, clk cycles per UART bit (>=2); 434 gives 115200 baud at 50 MHz.
- NUM_BYTES, derived as ceil(2*DATA_W/8), number of result bytes sent; localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- save_a_n  in  1  active-low load strobe for operand A.
- save_b_n  in  1  active-low load strobe for operand B.
- data_input  in  DATA_W  operand value.
- op  in  3  operation select, sampled on start.
- start  in  1  request one compute+transmit transaction.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse when the last stop bit ends.
- uart_txd  out  1  serial line, idle high.

Behaviour:
- Reset (async, immediate): A=B=0, result=0, FSM=IDLE, busy=0, done=0, uart_txd=1. A reset mid-frame drives the line high at once; no partial frame resumes.
- Operand load: on each clk edge with save_a_n=0, A<=data_input; likewise B with save_b_n=0. Both strobes may be low in the same cycle (both load). Loads are ignored while busy=1.
- Ops: 000 A+B; 001 A-B (two's complement, sign-extended to 2*DATA_W); 010 A*B unsigned; 011 A&B; 100 A|B; 101 A^B; 110 A passthrough; 111 compare, result = {zeros, A>B, A==B, A<B}. Logical ops and passthrough are zero-extended.
- Handshake:
  - start=1 in IDLE is accepted at cycle 0.
  - Cycle 1: op, A and B are captured, the result is registered, busy=1, FSM=LOAD.
  - Cycle 2: START state begins; uart_txd=0.
  - start while busy is ignored and not queued.
  - done pulses in the first cycle after the final stop bit completes.
  - busy falls in that same cycle; the FSM is back in IDLE and a new start can be accepted on that cycle.
- FSM states: IDLE -> LOAD -> START -> DATA -> STOP. From STOP: go to START if bytes remain, else IDLE.
- Bit timing: every bit lasts exactly CLKS_PER_BIT cycles via a baud counter. The counter is cleared on each state entry.
- Framing: data bits LSB first. Byte index counts 0..NUM_BYTES-1. The next byte's start bit follows the stop bit with no idle gap.
- Frame length: one frame = 10*CLKS_PER_BIT cycles; 11*CLKS_PER_BIT with parity.

Optional Feature:
- Macro: CALC_UART_PARITY_EN.
- When defined: a PARITY state sits between DATA and STOP and sends an even parity bit over the 8 data bits (8E1).
- When undefined: the state and its logic are absent, giving 8N1 with no parity cost.

Decomposition:
- Package calc_uart_pkg holds:
  - op encoding constants: OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_PASS, OP_CMP;
  - the FSM state typedef;
  - a function num_bytes(data_w).
- Sub-module uart_frame_ser owns the baud counter, bit counter and START/DATA/(PARITY)/STOP sequencing for one byte. Its interface is load/byte_in/ready.
- The top module owns the operand registers, the ALU and the byte sequencer.

Test Plan (DATA_W=8, CLKS_PER_BIT=4):
- Reset and idle: reset_n low then high -> uart_txd=1, busy=0, done=0; save strobes load A=0x0F, B=0x01 with no line activity.
- Add: A=0x0F, B=0x01, op=000, start -> busy=1 at cycle 1, start bit at cycle 2, bytes 0x10 then 0x00. done pulses at cycle 82 (2 + 80).
- Subtract: A=0x03, B=0x05, op=001 -> bytes 0xFE then 0xFF.
- Multiply and compare:
  - A=0xFF, B=0xFF, op=010 -> bytes 0x01 then 0xFE.
  - A=0x07, B=0x07, op=111 -> bytes 0x02 then 0x00.
- Ignored inputs while busy: start pulse and save_a_n=0 with data 0x55 mid-transmission -> frames unchanged, A unchanged. A new start on the done cycle is accepted.
- Reset mid-frame: reset_n low during the DATA state -> uart_txd=1 in the same cycle, busy=0. After release, a fresh add transaction sends correct frames. With CALC_UART_PARITY_EN, byte 0x10 carries parity bit 1.
